lcd_msg_queue: RTL
==================

# lcd_msg_queue

Character queue and cursor sequencer that sits directly upstream of the LCD write stage. Accepts ASCII bytes from a host over a valid/ready handshake and buffers them in a FIFO. Translates control bytes and line overflow into HD44780 commands. Emits a stream of (byte, rs) beats over a second valid/ready handshake, ready for the enable-strobe writer to put on the LCD pins.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2
- COLS, 16, visible columns per line
- LINE1_ADDR, 8'h80, set-DDRAM-address command for line 1, column 0
- LINE2_ADDR, 8'hC0, set-DDRAM-address command for line 2, column 0

Ports:
- clk  in  1  single clock for the whole block
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  host byte valid
- in_ready  out  1  FIFO not full
- in_data  in  8  host byte (ASCII, or control 8'h0A / 8'h0C)
- out_valid  out  1  output beat valid
- out_ready  in  1  LCD writer accepts beat
- out_data  out  8  byte to LCD
- out_rs  out  1  0 = command, 1 = character data
- level  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- FIFO: write on in_valid & in_ready. Read when the sequencer is in IDLE and the FIFO is non-empty. A simultaneous write and read leaves level unchanged. Pointers wrap modulo DEPTH.
- Cursor state: col (0..COLS) and line (0/1).
- Sequencer states: IDLE, CHAR, ADDR, CLEAR.
- IDLE: pop the head byte b. Then:
  - b==8'h0A (newline): load out_data = the other line's address, out_rs=0. Toggle line, set col=0, go to ADDR.
  - b==8'h0C (form feed): load out_data=8'h01, out_rs=0. Set line=0, col=0, go to CLEAR.
  - Otherwise, if col==COLS (autowrap): load the next line's address command, out_rs=0, hold b internally, go to ADDR-then-CHAR.
  - Otherwise: load b, out_rs=1, go to CHAR.
- CHAR: hold the beat until out_ready. On the handshake, col increments (saturating at COLS), then return to IDLE.
- ADDR/CLEAR: hold until out_ready. If a character is pending after a wrap, go to CHAR with that character and col=0. Otherwise go to IDLE.
- Line 2 overflow wraps to line 1 (LINE1_ADDR). No clear is issued.
- out_data and out_rs are stable while out_valid & !out_ready.

## Timing
- Reset values: out_valid=0, out_data=8'h00, out_rs=0, level=0, in_ready=1, col=0, line=0, state IDLE.
- Reset asserted mid-transfer: the beat is dropped, the FIFO is emptied, and the cursor returns to line 0, col 0.
- Latency: a byte written into an empty FIFO at edge N gives out_valid=1 after edge N+1.
- Throughput: with out_ready held high, one output beat per 2 cycles (pop, then handshake). A wrap adds 1 beat.
- in_ready = (level != DEPTH), combinational from level. A push attempted while full is ignored; level stays DEPTH.
- Output handshake completes on a cycle with out_valid & out_ready. out_valid drops on the next edge unless the next beat is loaded.

## Configuration
- LCD_MSG_AUTOWRAP_EN defined: when col==COLS, the next printable byte is preceded by the other line's address command.
- LCD_MSG_AUTOWRAP_EN undefined: no automatic address commands. Printable bytes are always emitted with out_rs=1, and col saturates at COLS. Only 8'h0A and 8'h0C move the cursor.

## Test plan
- Reset: assert reset_n=0 mid-beat. Required: out_valid=0, level=0, in_ready=1 at once. After release, "A" (8'h41) gives beat (8'h41, rs=1).
- Burst "HELLO", out_ready=1: five beats 48,45,4C,4C,4F, all rs=1, in order. No gaps beyond the 2-cycle cadence.
- Autowrap, COLS=16 (macro defined): write 17 × 8'h41. Required: 16 data beats, then (8'hC0, rs=0), then (8'h41, rs=1). Macro undefined: 17 data beats, no command.
- Control bytes: write 8'h42, 8'h0A, 8'h0C. Required: (42,1), (C0,0), (01,0); cursor ends at line 0, col 0.
- Backpressure/full: hold out_ready=0 and push DEPTH+3 bytes. Required: in_ready=0 once level==DEPTH, extra bytes dropped, and the held beat stays stable. Releasing out_ready drains exactly the accepted bytes, in order.

Source files
------------

// File: rtl/lcd_msg_queue.sv
// Character FIFO plus cursor sequencer that turns host bytes into HD44780 (byte, rs) beats.
// Define LCD_MSG_AUTOWRAP_EN to emit the other line's address command on column overflow.
module lcd_msg_queue #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned COLS       = 16,
    parameter logic [7:0]  LINE1_ADDR = 8'h80,
    parameter logic [7:0]  LINE2_ADDR = 8'hC0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic                     out_rs,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(COLS + 1);

    localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [CW-1:0] COL_MAX  = CW'(COLS);

    localparam logic [7:0] ChNewline  = 8'h0A;
    localparam logic [7:0] ChFormFeed = 8'h0C;
    localparam logic [7:0] CmdClear   = 8'h01;

    typedef enum logic [1:0] {StIdle, StChar, StAddr, StClear} state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic          line_q, line_d;
    logic          pend_q, pend_d;
    logic [7:0]    pend_data_q, pend_data_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_rs_q, out_rs_d;

    logic          push, pop;
    logic [7:0]    head;
    logic [7:0]    other_addr;

    assign in_ready   = (level_q != LVL_FULL);
    assign push       = in_valid && in_ready;
    assign pop        = (state_q == StIdle) && (level_q != '0);
    assign head       = mem_q[rd_ptr_q];
    assign other_addr = line_q ? LINE1_ADDR : LINE2_ADDR;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_rs    = out_rs_q;
    assign level     = level_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        line_d      = line_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_rs_d    = out_rs_q;

        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    out_valid_d = 1'b1;
                    if (head == ChNewline) begin
                        out_data_d = other_addr;
                        out_rs_d   = 1'b0;
                        line_d     = ~line_q;
                        col_d      = '0;
                        state_d    = StAddr;
                    end else if (head == ChFormFeed) begin
                        out_data_d = CmdClear;
                        out_rs_d   = 1'b0;
                        line_d     = 1'b0;
                        col_d      = '0;
                        state_d    = StClear;
                    end
`ifdef LCD_MSG_AUTOWRAP_EN
                    else if (col_q == COL_MAX) begin
                        // Park the printable byte until the address command is taken.
                        out_data_d  = other_addr;
                        out_rs_d    = 1'b0;
                        line_d      = ~line_q;
                        col_d       = '0;
                        pend_d      = 1'b1;
                        pend_data_d = head;
                        state_d     = StAddr;
                    end
`endif
                    else begin
                        out_data_d = head;
                        out_rs_d   = 1'b1;
                        state_d    = StChar;
                    end
                end
            end
            StChar: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (col_q != COL_MAX) begin
                        col_d = col_q + COL_ONE;
                    end
                    state_d = StIdle;
                end
            end
            StAddr, StClear: begin
                if (out_ready) begin
                    if (pend_q) begin
                        out_data_d = pend_data_q;
                        out_rs_d   = 1'b1;
                        pend_d     = 1'b0;
                        col_d      = '0;
                        state_d    = StChar;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            state_q     <= StIdle;
            col_q       <= '0;
            line_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_data_q <= 8'h00;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_rs_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            state_q     <= state_d;
            col_q       <= col_d;
            line_q      <= line_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_rs_q    <= out_rs_d;
        end
    end

endmodule
